// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - handshaked ALU with obstacle/velocity actions; ALU_MUL_EN adds a shift-add multiplier FSM.
`timescale 1ns/1ps
module pipelined_alu #(
    parameter int WIDTH  = 16,
    parameter int IMG_W  = 16,
    parameter int MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               opcode,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(IMG_W)-1:0] car_x,
    input  logic [IMG_W-1:0]         img_row,
    input  logic                     velocity_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     zero_flag,
    output logic                     negative_flag,
    output logic                     carry_flag,
    output logic                     overflow_flag,
    output logic                     illegal_op
);

    localparam logic [4:0] OP_NOP            = 5'd0;
    localparam logic [4:0] OP_MOV            = 5'd1;
    localparam logic [4:0] OP_LD             = 5'd2;
    localparam logic [4:0] OP_ST             = 5'd3;
    localparam logic [4:0] OP_ADD            = 5'd4;
    localparam logic [4:0] OP_SUB            = 5'd5;
    localparam logic [4:0] OP_AND            = 5'd6;
    localparam logic [4:0] OP_OR             = 5'd7;
    localparam logic [4:0] OP_NOT            = 5'd8;
    localparam logic [4:0] OP_JMP            = 5'd9;
    localparam logic [4:0] OP_MOVE_LEFT      = 5'd10;
    localparam logic [4:0] OP_MOVE_RIGHT     = 5'd11;
    localparam logic [4:0] OP_STOP           = 5'd12;
    localparam logic [4:0] OP_CONTINUE       = 5'd13;
    localparam logic [4:0] OP_VELOCITY_GUARD = 5'd14;
    localparam logic [4:0] OP_OB_CHECK       = 5'd15;

    localparam logic [WIDTH-1:0] ACTION_MOVE_LEFT  = {{(WIDTH-3){1'b0}}, 3'd1};
    localparam logic [WIDTH-1:0] ACTION_MOVE_RIGHT = {{(WIDTH-3){1'b0}}, 3'd2};
    localparam logic [WIDTH-1:0] ACTION_STOP       = {{(WIDTH-3){1'b0}}, 3'd3};
    localparam logic [WIDTH-1:0] ACTION_CONTINUE   = {{(WIDTH-3){1'b0}}, 3'd4};

    logic             accept;
    logic             single_wr;
    logic             mul_busy;
    logic             mul_wr;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;
    logic             s_ill;
    logic             ob_hit;

    assign accept = in_valid && in_ready;
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = a - b;

    // Window is clipped at both row edges rather than wrapping around.
    always_comb begin
        ob_hit = 1'b0;
        for (int i = 0; i < IMG_W; i++) begin
            if (i >= int'(car_x) - MARGIN && i <= int'(car_x) + MARGIN && img_row[i])
                ob_hit = 1'b1;
        end
    end

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_ill = 1'b0;
        case (opcode)
            OP_MOV, OP_LD, OP_ST: s_res = b;
            OP_ADD: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = diff;
                s_c   = a < b;
                s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:            s_res = a & b;
            OP_OR:             s_res = a | b;
            OP_NOT:            s_res = ~a;
            OP_JMP:            s_res = a;
            OP_NOP:            s_res = '0;
            OP_MOVE_LEFT:      s_res = ACTION_MOVE_LEFT;
            OP_MOVE_RIGHT:     s_res = ACTION_MOVE_RIGHT;
            OP_STOP:           s_res = ACTION_STOP;
            OP_CONTINUE:       s_res = ACTION_CONTINUE;
            OP_VELOCITY_GUARD: s_res = velocity_en ? ACTION_CONTINUE : ACTION_STOP;
            OP_OB_CHECK:       s_res = ob_hit ? ACTION_STOP : ACTION_CONTINUE;
            default:           s_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd16;
    localparam int         CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    mul_state_t         state;
    mul_state_t         state_nxt;
    logic [CNT_W-1:0]   mul_cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               mul_start;

    assign mul_start = accept && (opcode == OP_MUL);
    assign mul_busy  = (state != MUL_IDLE);
    assign mul_wr    = (state == MUL_DONE) && (!out_valid || out_ready);
    assign single_wr = accept && (opcode != OP_MUL);
    assign mul_lo    = acc[WIDTH-1:0];
    assign mul_hi_nz = |acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MUL_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (mul_start) state_nxt = MUL_BUSY;
            MUL_BUSY: if (mul_cnt == CNT_W'(WIDTH - 1)) state_nxt = MUL_DONE;
            MUL_DONE: if (!out_valid || out_ready) state_nxt = MUL_IDLE;
            default:  state_nxt = MUL_IDLE;
        endcase
    end

    // One multiplier bit per BUSY cycle; acc is final when DONE is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else if (mul_start) begin
            mul_cnt <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
        end else if (state == MUL_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end

    assign in_ready = !mul_busy && (!out_valid || out_ready);
`else
    assign mul_busy  = 1'b0;
    assign mul_wr    = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
    assign single_wr = accept;
    assign in_ready  = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (single_wr) begin
            out_valid     <= 1'b1;
            result        <= s_res;
            zero_flag     <= (s_res == '0);
            negative_flag <= s_res[WIDTH-1];
            carry_flag    <= s_c;
            overflow_flag <= s_v;
            illegal_op    <= s_ill;
        end else if (mul_wr) begin
            out_valid     <= 1'b1;
            result        <= mul_lo;
            zero_flag     <= (mul_lo == '0);
            negative_flag <= mul_lo[WIDTH-1];
            carry_flag    <= mul_hi_nz;
            overflow_flag <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule
